uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter among N_REQ byte-stream requesters using round-robin arbitration.
- Ownership is message-granular: once granted, a requester keeps the transmitter until it sends a byte flagged last, or until a hold timeout expires.
- Sequences the UART's data_tx/data_tx_vld/rdy handshake so that no byte is issued while the UART is busy.
- Sits between client logic (debug, status, command-response) and the UART core.

---
 rtl/uart_tx_arbiter.sv | 170 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter that shares one UART transmitter among N_REQ byte streams.
// Each byte is issued only when the UART is ready, then the arbiter waits for the frame to go busy and finish.
//
// state     | meaning
// IDLE      | no owner; pick next requester searching from ptr
// ISSUE     | owner holds grant; hand its next byte to the UART when ready
// WAIT_BUSY | byte issued; wait for UART rdy to drop
// WAIT_DONE | UART shifting the frame; wait for rdy to return
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int HOLD_TIMEOUT = 100000,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [8*N_REQ-1:0] req_data_i,
    input  logic [N_REQ-1:0]   req_vld_i,
    input  logic [N_REQ-1:0]   req_last_i,
    output logic [N_REQ-1:0]   req_ack_o,
    output logic [N_REQ-1:0]   grant_o,
    output logic [7:0]         uart_data_o,
    output logic               uart_vld_o,
    input  logic               uart_rdy_i,
    output logic               busy_o,
    output logic               err_o
);

    localparam int IW = $clog2(N_REQ);
    localparam int HW = $clog2(HOLD_TIMEOUT + 1);
    localparam int BW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_TIMEOUT - 1);
    localparam logic [BW-1:0] BUSY_LOAD = BW'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [IW-1:0]   owner, owner_n;
    logic [IW-1:0]   ptr, ptr_n;
    logic [IW-1:0]   release_ptr;
    logic [IW-1:0]   pick, cand;
    logic            found;
    logic [HW-1:0]   hold_cnt, hold_cnt_n;
    logic [BW-1:0]   busy_cnt, busy_cnt_n;
    logic            last_q, last_n;
    logic [N_REQ-1:0] ack_n, grant_n;
    logic [7:0]      data_n;
    logic            vld_n, err_n;

    assign release_ptr = (owner == IW'(N_REQ - 1)) ? '0 : owner + 1'b1;

    // First requesting index at or after ptr, wrapping modulo N_REQ.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = IW'((int'(ptr) + i) % N_REQ);
            if (!found && req_vld_i[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_n    = state;
        owner_n    = owner;
        ptr_n      = ptr;
        hold_cnt_n = hold_cnt;
        busy_cnt_n = busy_cnt;
        last_n     = last_q;
        data_n     = uart_data_o;
        vld_n      = 1'b0;
        ack_n      = '0;
        err_n      = 1'b0;
        grant_n    = '0;

        unique case (state)
            IDLE: begin
                if (found) begin
                    owner_n    = pick;
                    hold_cnt_n = HOLD_LOAD;
                    state_n    = ISSUE;
                end
            end
            ISSUE: begin
                if (req_vld_i[owner]) begin
                    if (uart_rdy_i) begin
                        vld_n        = 1'b1;
                        data_n       = req_data_i[{owner, 3'b000} +: 8];
                        ack_n[owner] = 1'b1;
                        last_n       = req_last_i[owner];
                        hold_cnt_n   = HOLD_LOAD;
                        busy_cnt_n   = BUSY_LOAD;
                        state_n      = WAIT_BUSY;
                    end
                end else if (hold_cnt == '0) begin
                    err_n   = 1'b1;
                    ptr_n   = release_ptr;
                    state_n = IDLE;
                end else begin
                    hold_cnt_n = hold_cnt - 1'b1;
                end
            end
            WAIT_BUSY: begin
                if (!uart_rdy_i) begin
                    state_n = WAIT_DONE;
                end else if (busy_cnt == '0) begin
                    err_n   = 1'b1;
                    ptr_n   = release_ptr;
                    state_n = IDLE;
                end else begin
                    busy_cnt_n = busy_cnt - 1'b1;
                end
            end
            WAIT_DONE: begin
                if (uart_rdy_i) begin
                    if (last_q) begin
                        ptr_n   = release_ptr;
                        state_n = IDLE;
                    end else begin
                        hold_cnt_n = HOLD_LOAD;
                        state_n    = ISSUE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (state_n != IDLE) begin
            grant_n[owner_n] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            owner       <= '0;
            ptr         <= '0;
            hold_cnt    <= '0;
            busy_cnt    <= '0;
            last_q      <= 1'b0;
            req_ack_o   <= '0;
            grant_o     <= '0;
            uart_data_o <= 8'h00;
            uart_vld_o  <= 1'b0;
            busy_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            state       <= state_n;
            owner       <= owner_n;
            ptr         <= ptr_n;
            hold_cnt    <= hold_cnt_n;
            busy_cnt    <= busy_cnt_n;
            last_q      <= last_n;
            req_ack_o   <= ack_n;
            grant_o     <= grant_n;
            uart_data_o <= data_n;
            uart_vld_o  <= vld_n;
            busy_o      <= (state_n != IDLE);
            err_o       <= err_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: requester queues, a UART rdy model and a message-level
// round-robin reference that predicts the byte order on the UART.
module tb_uart_tx_arbiter;
    localparam int N     = 4;
    localparam int HOLD  = 50;
    localparam int BUSYT = 16;

    logic           clk_i = 1'b0;
    logic           rst_i = 1'b1;
    logic [8*N-1:0] req_data_i = '0;
    logic [N-1:0]   req_vld_i = '0;
    logic [N-1:0]   req_last_i = '0;
    logic [N-1:0]   req_ack_o;
    logic [N-1:0]   grant_o;
    logic [7:0]     uart_data_o;
    logic           uart_vld_o;
    logic           uart_rdy_i = 1'b1;
    logic           busy_o;
    logic           err_o;

    uart_tx_arbiter #(.N_REQ(N), .HOLD_TIMEOUT(HOLD), .BUSY_TIMEOUT(BUSYT)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_data_i(req_data_i), .req_vld_i(req_vld_i),
        .req_last_i(req_last_i), .req_ack_o(req_ack_o), .grant_o(grant_o),
        .uart_data_o(uart_data_o), .uart_vld_o(uart_vld_o), .uart_rdy_i(uart_rdy_i),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Per-requester byte queues: {last, data}. Reference output: {requester, data}.
    logic [8:0] rq [N][$];
    logic [8:0] mq [N][$];
    logic [9:0] exp_q [$];
    int model_ptr = 0;

    int u_drop = 1, u_frame = 20, u_drop_cnt = 0, u_frame_left = 0;
    bit u_stuck = 1'b0;

    logic prev_vld = 1'b0;
    logic [N-1:0] prev_grant = '0;
    int vld_cnt = 0, ack_cnt = 0, err_cnt = 0;
    int last_vld_cyc = -1, exp_err_cyc = -1, grant_fall_cyc = -1;
    int vld_cyc_q [$];
    int grant_seq [$];

    task automatic drive_reqs();
        for (int k = 0; k < N; k++) begin
            if (rq[k].size() > 0) begin
                req_vld_i[k]         = 1'b1;
                req_last_i[k]        = rq[k][0][8];
                req_data_i[8*k +: 8] = rq[k][0][7:0];
            end else begin
                req_vld_i[k]         = 1'b0;
                req_last_i[k]        = 1'b0;
                req_data_i[8*k +: 8] = 8'h00;
            end
        end
    endtask

    // Whole messages go out in turn, starting at the first non-empty queue from model_ptr.
    task automatic build_expected();
        int k;
        int c;
        logic [8:0] e;
        for (int i = 0; i < N; i++) mq[i] = rq[i];
        for (int guard = 0; guard < 256; guard++) begin
            k = -1;
            for (int i = 0; i < N; i++) begin
                c = (model_ptr + i) % N;
                if (k < 0 && mq[c].size() > 0) k = c;
            end
            if (k < 0) break;
            do begin
                e = mq[k].pop_front();
                exp_q.push_back({2'(k), e[7:0]});
            end while (!e[8] && mq[k].size() > 0);
            model_ptr = (k + 1) % N;
        end
    endtask

    task automatic cycle();
        logic [9:0] e;
        logic [N-1:0] onehot;
        @(posedge clk_i);
        #1;
        cyc++;

        checks++;
        if (!$onehot0(grant_o) || busy_o !== (grant_o != '0)) begin
            errors++;
            $display("FAIL grant_busy cyc=%0d: grant=%b busy=%b, need one-hot-or-zero grant and busy=|grant", cyc, grant_o, busy_o);
        end

        if (uart_vld_o || req_ack_o != '0) begin
            checks++;
            if (!uart_vld_o || prev_vld) begin
                errors++;
                $display("FAIL vld_pulse cyc=%0d: vld=%b prev_vld=%b ack=%b", cyc, uart_vld_o, prev_vld, req_ack_o);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_byte cyc=%0d: data=%h ack=%b, no byte expected", cyc, uart_data_o, req_ack_o);
            end else begin
                e = exp_q.pop_front();
                onehot = '0;
                onehot[e[9:8]] = 1'b1;
                if (uart_data_o !== e[7:0] || req_ack_o !== onehot || grant_o !== onehot) begin
                    errors++;
                    $display("FAIL byte cyc=%0d: data=%h ack=%b grant=%b, expected data=%h owner=%b", cyc, uart_data_o, req_ack_o, grant_o, e[7:0], onehot);
                end
            end
            if (uart_vld_o) begin
                vld_cnt++;
                last_vld_cyc = cyc;
                vld_cyc_q.push_back(cyc);
            end
        end
        ack_cnt += $countones(req_ack_o);
        prev_vld = uart_vld_o;

        if (err_o) begin
            err_cnt++;
            checks++;
            if (cyc != exp_err_cyc) begin
                errors++;
                $display("FAIL err_timing: err_o at cyc %0d, expected at cyc %0d", cyc, exp_err_cyc);
            end
        end

        if (grant_o != '0 && prev_grant == '0) begin
            for (int k = 0; k < N; k++) if (grant_o[k]) grant_seq.push_back(k);
        end
        if (grant_o == '0 && prev_grant != '0) grant_fall_cyc = cyc;
        prev_grant = grant_o;

        for (int k = 0; k < N; k++) begin
            if (req_ack_o[k] && rq[k].size() > 0) void'(rq[k].pop_front());
        end

        if (u_frame_left > 0) begin
            u_frame_left--;
            if (u_frame_left == 0) uart_rdy_i = 1'b1;
        end else if (u_drop_cnt > 0) begin
            u_drop_cnt--;
            if (u_drop_cnt == 0) begin
                uart_rdy_i   = 1'b0;
                u_frame_left = u_frame;
            end
        end
        if (uart_vld_o && !u_stuck) u_drop_cnt = u_drop;

        drive_reqs();
    endtask

    task automatic run_until_idle(input int budget, input string name);
        bit done;
        done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            cycle();
            done = (exp_q.size() == 0) && (grant_o == '0) && !busy_o && uart_rdy_i
                   && (u_frame_left == 0) && (u_drop_cnt == 0);
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout: %0d bytes still expected after %0d cycles, grant=%b", name, exp_q.size(), budget, grant_o);
            exp_q.delete();
        end
    endtask

    task automatic wait_vld(input int v0, input string name);
        for (int n = 0; n < 40 && vld_cnt == v0; n++) cycle();
        checks++;
        if (vld_cnt == v0) begin
            errors++;
            $display("FAIL %s_no_vld: vld_count=%0d, expected a new byte within 40 cycles", name, vld_cnt);
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        cycle();
        cycle();
        rst_i = 1'b0;
        exp_q.delete();
        model_ptr = 0;
        exp_err_cyc = -1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        rq[2].push_back({1'b1, 8'($urandom_range(255))});
        drive_reqs();
        cycle();
        cycle();
        cycle();
        checks++;
        if ({req_ack_o, grant_o, uart_data_o, uart_vld_o, busy_o, err_o} !== '0) begin
            errors++;
            $display("FAIL reset_values: ack=%b grant=%b data=%h vld=%b busy=%b err=%b, all must be 0", req_ack_o, grant_o, uart_data_o, uart_vld_o, busy_o, err_o);
        end
        rst_i = 1'b0;
        model_ptr = 0;
        build_expected();
        run_until_idle(200, "reset_release");
    endtask

    task automatic test_single();
        int a0;
        u_drop  = 1;
        u_frame = 20;
        a0 = ack_cnt;
        vld_cyc_q.delete();
        rq[0].push_back(9'h041);
        rq[0].push_back(9'h042);
        rq[0].push_back(9'h143);
        build_expected();
        drive_reqs();
        run_until_idle(300, "single");
        checks++;
        if (vld_cyc_q.size() != 3 || ack_cnt - a0 != 3) begin
            errors++;
            $display("FAIL single_count: vld=%0d ack=%0d, expected 3 and 3", vld_cyc_q.size(), ack_cnt - a0);
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (vld_cyc_q[i] - vld_cyc_q[i-1] < 22) begin
                    errors++;
                    $display("FAIL single_spacing: gap=%0d cycles, expected >= 22", vld_cyc_q[i] - vld_cyc_q[i-1]);
                end
            end
            checks++;
            if (grant_fall_cyc != vld_cyc_q[2] + 22) begin
                errors++;
                $display("FAIL single_release: grant fell at cyc %0d, expected %0d", grant_fall_cyc, vld_cyc_q[2] + 22);
            end
        end
    endtask

    task automatic test_two_req();
        rst_i = 1'b1;
        exp_q.delete();
        grant_seq.delete();
        rq[0].push_back({1'b0, 8'($urandom_range(255))});
        rq[0].push_back({1'b1, 8'($urandom_range(255))});
        rq[2].push_back({1'b0, 8'($urandom_range(255))});
        rq[2].push_back({1'b1, 8'($urandom_range(255))});
        drive_reqs();
        cycle();
        cycle();
        rst_i = 1'b0;
        model_ptr = 0;
        build_expected();
        run_until_idle(400, "two_req");
        // 0 and 3 now compete; ptr left at 3 means 3 goes first.
        rq[0].push_back({1'b1, 8'($urandom_range(255))});
        rq[3].push_back({1'b1, 8'($urandom_range(255))});
        build_expected();
        drive_reqs();
        run_until_idle(400, "two_req_ptr");
        checks++;
        if (grant_seq.size() != 4 || grant_seq[0] != 0 || grant_seq[1] != 2 || grant_seq[2] != 3 || grant_seq[3] != 0) begin
            errors++;
            $display("FAIL two_req_order: grant sequence %p, expected 0 2 3 0", grant_seq);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        grant_seq.delete();
        u_frame = $urandom_range(12, 3);
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < N; k++) rq[k].push_back({1'b1, 8'($urandom_range(255))});
        build_expected();
        drive_reqs();
        run_until_idle(800, "round_robin");
        checks++;
        if (grant_seq.size() != 8) begin
            errors++;
            $display("FAIL rr_count: %0d grants, expected 8", grant_seq.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (grant_seq[i] != i % N) begin
                    errors++;
                    $display("FAIL rr_order: grant %0d went to %0d, expected %0d", i, grant_seq[i], i % N);
                end
            end
        end
    endtask

    task automatic test_hold_timeout();
        int e0;
        int v0;
        logic [7:0] b;
        do_reset();
        u_drop  = 1;
        u_frame = $urandom_range(10, 2);
        e0 = err_cnt;
        v0 = vld_cnt;
        b  = 8'($urandom_range(255));
        rq[1].push_back(9'h010);
        rq[2].push_back({1'b1, b});
        exp_q.push_back({2'd1, 8'h10});
        exp_q.push_back({2'd2, b});
        drive_reqs();
        wait_vld(v0, "hold");
        exp_err_cyc = last_vld_cyc + u_frame + 2 + HOLD;
        for (int n = 0; n < 200 && cyc < exp_err_cyc; n++) cycle();
        checks++;
        if (err_o !== 1'b1 || grant_o !== '0) begin
            errors++;
            $display("FAIL hold_release: err=%b grant=%b at cyc %0d, expected err=1 grant=0000", err_o, grant_o, cyc);
        end
        cycle();
        checks++;
        if (grant_o !== 4'b0100) begin
            errors++;
            $display("FAIL hold_next_owner: grant=%b, expected 0100", grant_o);
        end
        model_ptr = 3;
        run_until_idle(200, "hold");
        checks++;
        if (err_cnt - e0 != 1) begin
            errors++;
            $display("FAIL hold_err_count: %0d err pulses, expected 1", err_cnt - e0);
        end
    endtask

    task automatic test_busy_timeout();
        int v0;
        logic [7:0] b;
        do_reset();
        u_stuck = 1'b1;
        v0 = vld_cnt;
        b  = 8'($urandom_range(255));
        rq[0].push_back({1'b1, b});
        exp_q.push_back({2'd0, b});
        drive_reqs();
        wait_vld(v0, "busy");
        exp_err_cyc = last_vld_cyc + BUSYT;
        for (int n = 0; n < 40 && cyc < exp_err_cyc; n++) cycle();
        checks++;
        if (err_o !== 1'b1 || busy_o !== 1'b0 || grant_o !== '0) begin
            errors++;
            $display("FAIL busy_timeout: err=%b busy=%b grant=%b at cyc %0d, expected 1 0 0000", err_o, busy_o, grant_o, cyc);
        end
        cycle();
        checks++;
        if (err_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL busy_err_pulse: err=%b busy=%b one cycle later, expected 0 0", err_o, busy_o);
        end
        u_stuck = 1'b0;
        model_ptr = 1;
        run_until_idle(100, "busy");
    endtask

    task automatic test_reset_mid();
        int v0;
        u_drop  = 1;
        u_frame = $urandom_range(15, 8);
        v0 = vld_cnt;
        rq[0].push_back({1'b0, 8'($urandom_range(255))});
        rq[0].push_back({1'b1, 8'($urandom_range(255))});
        exp_q.push_back({2'd0, rq[0][0][7:0]});
        drive_reqs();
        wait_vld(v0, "reset_mid");
        for (int n = 0; n < 5; n++) cycle();
        rst_i = 1'b1;
        rq[3].push_back({1'b1, 8'($urandom_range(255))});
        drive_reqs();
        grant_seq.delete();
        cycle();
        checks++;
        if ({req_ack_o, grant_o, uart_data_o, uart_vld_o, busy_o, err_o} !== '0) begin
            errors++;
            $display("FAIL reset_mid_values: ack=%b grant=%b data=%h vld=%b busy=%b err=%b, all must be 0", req_ack_o, grant_o, uart_data_o, uart_vld_o, busy_o, err_o);
        end
        rst_i = 1'b0;
        model_ptr = 0;
        build_expected();
        run_until_idle(200, "reset_mid");
        checks++;
        if (grant_seq.size() != 2 || grant_seq[0] != 0 || grant_seq[1] != 3) begin
            errors++;
            $display("FAIL reset_mid_order: grant sequence %p, expected 0 3", grant_seq);
        end
    endtask

    task automatic test_random();
        int mask;
        int nmsg;
        int len;
        for (int round = 0; round < 8; round++) begin
            u_drop  = $urandom_range(3, 1);
            u_frame = $urandom_range(12, 1);
            mask    = $urandom_range(15, 1);
            for (int k = 0; k < N; k++) begin
                if (mask[k]) begin
                    nmsg = $urandom_range(2, 1);
                    for (int m = 0; m < nmsg; m++) begin
                        len = $urandom_range(3, 1);
                        for (int i = 0; i < len; i++)
                            rq[k].push_back({(i == len - 1) ? 1'b1 : 1'b0, 8'($urandom_range(255))});
                    end
                end
            end
            build_expected();
            drive_reqs();
            run_until_idle(1500, "random");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_req();
        test_round_robin();
        test_hold_timeout();
        test_busy_timeout();
        test_reset_mid();
        test_random();
        checks++;
        if (exp_q.size() != 0 || vld_cnt != ack_cnt) begin
            errors++;
            $display("FAIL totals: %0d bytes outstanding, vld=%0d ack=%0d", exp_q.size(), vld_cnt, ack_cnt);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded 50000 cycles at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
